// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, registered output slot
// plus a one-entry skid toward Decode, and redirect handling that squashes stale fetches.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   input  logic        redirect,
   input  logic [31:0] redirectPC,
   input  logic        decReady,
   output logic        instrValid,
   output logic [31:0] INSTR,
   output logic [31:0] PC,
   output logic [31:0] PC4
);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic        out_vld_q, out_vld_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_pc4_q, out_pc4_d;
   logic        skid_vld_q, skid_vld_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        xfer, ack;

   always_comb begin
      xfer         = out_vld_q & decReady;
      ack          = imemAck & req_q;
      state_d      = state_q;
      fpc_d        = fpc_q;
      addr_d       = addr_q;
      out_vld_d    = out_vld_q;
      out_instr_d  = out_instr_q;
      out_pc_d     = out_pc_q;
      out_pc4_d    = out_pc4_q;
      skid_vld_d   = skid_vld_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      if (xfer) begin
         out_vld_d  = skid_vld_q;
         skid_vld_d = 1'b0;
         if (skid_vld_q) begin
            out_instr_d = skid_instr_q;
            out_pc_d    = skid_pc_q;
            out_pc4_d   = skid_pc_q + 32'd4;
         end
      end

      // Redirect wins over everything; an in-flight request must still be drained in DROP.
      if (redirect) begin
         fpc_d      = redirectPC & 32'hFFFF_FFFC;
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
         unique case (state_q)
            WAIT:    state_d = ack ? IDLE : DROP;
            DROP:    state_d = ack ? IDLE : DROP;
            default: state_d = IDLE;
         endcase
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!skid_vld_d) state_d = WAIT;
            end
            WAIT: begin
               if (ack) begin
                  if (!out_vld_q || xfer) begin
                     out_vld_d   = 1'b1;
                     out_instr_d = imemData;
                     out_pc_d    = fpc_q;
                     out_pc4_d   = fpc_q + 32'd4;
                  end else begin
                     skid_vld_d   = 1'b1;
                     skid_instr_d = imemData;
                     skid_pc_d    = fpc_q;
                  end
                  fpc_d   = fpc_q + 32'd4;
                  state_d = skid_vld_d ? IDLE : WAIT;
               end
            end
            default: begin
               if (ack) state_d = IDLE;
            end
         endcase
      end

      req_d = (state_d != IDLE);
      // Latch a new address only when a fresh request starts; DROP keeps the old one.
      if (state_d == WAIT && (state_q != WAIT || ack)) addr_d = fpc_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         fpc_q        <= RESET_PC;
         addr_q       <= RESET_PC;
         req_q        <= 1'b0;
         out_vld_q    <= 1'b0;
         out_instr_q  <= NOP;
         out_pc_q     <= RESET_PC;
         out_pc4_q    <= RESET_PC + 32'd4;
         skid_vld_q   <= 1'b0;
         skid_instr_q <= NOP;
         skid_pc_q    <= RESET_PC;
      end else begin
         state_q      <= state_d;
         fpc_q        <= fpc_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         out_vld_q    <= out_vld_d;
         out_instr_q  <= out_instr_d;
         out_pc_q     <= out_pc_d;
         out_pc4_q    <= out_pc4_d;
         skid_vld_q   <= skid_vld_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   assign imemReq    = req_q;
   assign imemAddr   = addr_q;
   assign instrValid = out_vld_q;
   assign INSTR      = out_vld_q ? out_instr_q : NOP;
   assign PC         = out_pc_q;
   assign PC4        = out_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle table, backpressure/reset sequences,
// and a randomized run checked against an address-stream reference model.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOPI   = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck = 1'b0;
   logic [31:0] imemData = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirectPC = '0;
   logic        decReady = 1'b0;
   logic        instrValid;
   logic [31:0] INSTR, PC, PC4;

   int checks = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(RST_PC), .NOP(NOPI)) dut (
      .clock(clock), .reset(reset),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
      .redirect(redirect), .redirectPC(redirectPC), .decReady(decReady),
      .instrValid(instrValid), .INSTR(INSTR), .PC(PC), .PC4(PC4)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Memory contents are a hash of the address, so a word from the wrong address is visible.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   {31'd0, imemReq}, 32'd0);
      chk({tag, "_addr"},  imemAddr, RST_PC);
      chk({tag, "_vld"},   {31'd0, instrValid}, 32'd0);
      chk({tag, "_instr"}, INSTR, NOPI);
      chk({tag, "_pc"},    PC, RST_PC);
      chk({tag, "_pc4"},   PC4, RST_PC + 32'd4);
   endtask

   task automatic drive(input logic ack, input logic [31:0] data, input logic rd,
                        input logic [31:0] rpc, input logic rdy);
      imemAck = ack; imemData = data; redirect = rd; redirectPC = rpc; decReady = rdy;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      reset = 1'b0;
      #1;
      chk_reset_outputs("reset");
      @(negedge clock);
      reset = 1'b1;
   endtask

   typedef struct {
      logic ack; logic [31:0] data; logic rd; logic [31:0] rpc; logic rdy;
      logic req; logic chk_addr; logic [31:0] addr;
      logic vld; logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4;
   } vec_t;

   function automatic vec_t mk(input logic ack, input logic [31:0] data, input logic rd,
                               input logic [31:0] rpc, input logic rdy, input logic req,
                               input logic ca, input logic [31:0] addr, input logic vld,
                               input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] pc4);
      vec_t v;
      v.ack = ack; v.data = data; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
      v.req = req; v.chk_addr = ca; v.addr = addr;
      v.vld = vld; v.instr = instr; v.pc = pc; v.pc4 = pc4;
      return v;
   endfunction

   vec_t tbl[17];

   initial begin
      logic [31:0] exp_pc, prev_addr;
      logic        redir_prev, prev_req, prev_ack, seen;
      int          ntx;

      tbl[0]  = mk(0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h0,         0, NOPI,          32'h0,         32'h4);
      tbl[1]  = mk(1, 32'h0050_0093, 0, 32'h0,         1, 1, 1, 32'h4,         1, 32'h0050_0093, 32'h0,         32'h4);
      tbl[2]  = mk(1, 32'h00A0_0113, 0, 32'h0,         1, 1, 1, 32'h8,         1, 32'h00A0_0113, 32'h4,         32'h8);
      tbl[3]  = mk(0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h8,         0, NOPI,          32'h4,         32'h8);
      tbl[4]  = mk(0, 32'h0,         1, 32'h100,       1, 1, 1, 32'h8,         0, NOPI,          32'h4,         32'h8);
      tbl[5]  = mk(0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h8,         0, NOPI,          32'h4,         32'h8);
      tbl[6]  = mk(0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h8,         0, NOPI,          32'h4,         32'h8);
      tbl[7]  = mk(1, 32'hDEAD_BEEF, 0, 32'h0,         1, 0, 0, 32'h0,         0, NOPI,          32'h4,         32'h8);
      tbl[8]  = mk(0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h100,       0, NOPI,          32'h4,         32'h8);
      tbl[9]  = mk(1, 32'h1111_1111, 0, 32'h0,         1, 1, 1, 32'h104,       1, 32'h1111_1111, 32'h100,       32'h104);
      tbl[10] = mk(1, 32'h2222_2222, 1, 32'h103,       1, 0, 0, 32'h0,         0, NOPI,          32'h100,       32'h104);
      tbl[11] = mk(0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h100,       0, NOPI,          32'h100,       32'h104);
      tbl[12] = mk(1, 32'h3333_3333, 0, 32'h0,         1, 1, 1, 32'h104,       1, 32'h3333_3333, 32'h100,       32'h104);
      tbl[13] = mk(0, 32'h0,         1, 32'hFFFF_FFFC, 1, 1, 1, 32'h104,       0, NOPI,          32'h100,       32'h104);
      tbl[14] = mk(1, 32'h4444_4444, 0, 32'h0,         1, 0, 0, 32'h0,         0, NOPI,          32'h100,       32'h104);
      tbl[15] = mk(0, 32'h0,         0, 32'h0,         1, 1, 1, 32'hFFFF_FFFC, 0, NOPI,          32'h100,       32'h104);
      tbl[16] = mk(1, 32'h5555_5555, 0, 32'h0,         1, 1, 1, 32'h0,         1, 32'h5555_5555, 32'hFFFF_FFFC, 32'h0);

      // Directed cycle table: basic fetch, redirect in WAIT, redirect with ack, wrap.
      apply_reset();
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].ack, tbl[i].data, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
         @(posedge clock);
         #1;
         chk($sformatf("tbl%0d_req", i), {31'd0, imemReq}, {31'd0, tbl[i].req});
         if (tbl[i].chk_addr) chk($sformatf("tbl%0d_addr", i), imemAddr, tbl[i].addr);
         chk($sformatf("tbl%0d_vld", i), {31'd0, instrValid}, {31'd0, tbl[i].vld});
         chk($sformatf("tbl%0d_instr", i), INSTR, tbl[i].instr);
         chk($sformatf("tbl%0d_pc", i), PC, tbl[i].pc);
         chk($sformatf("tbl%0d_pc4", i), PC4, tbl[i].pc4);
         @(negedge clock);
      end

      // Backpressure: slot and skid fill, request stops, then both drain in order.
      apply_reset();
      drive(0, '0, 0, '0, 0);
      @(posedge clock); #1;
      chk("bp_req0", {31'd0, imemReq}, 32'd1);
      chk("bp_addr0", imemAddr, 32'h0);
      @(negedge clock); drive(1, 32'h0050_0093, 0, '0, 0);
      @(posedge clock); #1;
      chk("bp_addr4", imemAddr, 32'h4);
      @(negedge clock); drive(1, 32'h00A0_0113, 0, '0, 0);
      @(posedge clock); #1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_stall%0d_req", c), {31'd0, imemReq}, 32'd0);
         chk($sformatf("bp_stall%0d_vld", c), {31'd0, instrValid}, 32'd1);
         chk($sformatf("bp_stall%0d_instr", c), INSTR, 32'h0050_0093);
         chk($sformatf("bp_stall%0d_pc", c), PC, 32'h0);
         @(negedge clock); drive(0, '0, 0, '0, 0);
         @(posedge clock); #1;
      end
      @(negedge clock); drive(0, '0, 0, '0, 1);
      @(posedge clock); #1;
      chk("bp_drain_instr", INSTR, 32'h00A0_0113);
      chk("bp_drain_pc", PC, 32'h4);
      chk("bp_drain_vld", {31'd0, instrValid}, 32'd1);
      chk("bp_drain_req", {31'd0, imemReq}, 32'd1);
      chk("bp_drain_addr", imemAddr, 32'h8);
      @(negedge clock); drive(1, 32'h0000_C0DE, 0, '0, 1);
      @(posedge clock); #1;
      chk("bp_full_instr", INSTR, 32'h0000_C0DE);
      chk("bp_full_pc", PC, 32'h8);
      chk("bp_full_addr", imemAddr, 32'hC);

      // Asynchronous reset while WAIT with a full output slot.
      #2;
      drive(0, '0, 0, '0, 0);
      reset = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      @(negedge clock);
      reset = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 2 && !seen; c++) begin
         @(posedge clock); #1;
         if (imemReq && imemAddr == RST_PC) seen = 1'b1;
      end
      chk("first_req_after_reset", {31'd0, seen}, 32'd1);

      // Randomized run against an in-order address-stream model.
      apply_reset();
      exp_pc = RST_PC; redir_prev = 0; prev_req = 0; prev_ack = 0; prev_addr = '0; ntx = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (redir_prev) chk("vld_after_redirect", {31'd0, instrValid}, 32'd0);
         if (prev_req && !prev_ack) begin
            chk("req_hold", {31'd0, imemReq}, 32'd1);
            chk("addr_hold", imemAddr, prev_addr);
         end
         if (!instrValid) chk("nop_when_empty", INSTR, NOPI);

         decReady = ($urandom_range(0, 3) != 0);
         if (imemReq) begin
            imemAck  = ($urandom_range(0, 2) == 0);
            imemData = imemAck ? mem(imemAddr) : $urandom;
         end else begin
            imemAck  = ($urandom_range(0, 7) == 0);
            imemData = 32'hBAD0_0000 | $urandom_range(0, 16'hFFFF);
         end
         redirect = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 2))
            0:       redirectPC = $urandom;
            1:       redirectPC = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            default: redirectPC = $urandom_range(0, 255);
         endcase

         if (instrValid && decReady) begin
            chk("stream_pc", PC, exp_pc);
            chk("stream_instr", INSTR, mem(exp_pc));
            chk("stream_pc4", PC4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            ntx++;
         end
         if (redirect) exp_pc = redirectPC & 32'hFFFF_FFFC;
         redir_prev = redirect;
         prev_req   = imemReq;
         prev_addr  = imemAddr;
         prev_ack   = imemAck && imemReq;
         @(posedge clock);
         @(negedge clock);
      end
      chk("progress", {31'd0, ntx >= 100}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
